// File: rtl/data_mem_responder.sv
// Load/store responder: synchronous-RAM data memory behind a one-at-a-time
// valid/ready request port, answering after a fixed number of wait cycles.
module data_mem_responder #(
    parameter int                    DATA_WIDTH = 64,
    parameter int                    ADDR_WIDTH = 64,
    parameter int                    DEPTH      = 4096,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 64'h80000000,
    parameter int                    LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wen,
    input  logic [1:0]            req_size,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic [1:0]            dbgState
);
    // Handshakes: a transfer happens on a rising edge where valid && ready are
    // both high; valid never waits on ready and the payload holds while valid.

    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

    state_t                  state, stateNext;
    logic                    wenQ;
    logic [1:0]              sizeQ;
    logic [ADDR_WIDTH-1:0]   addrQ;
    logic [DATA_WIDTH-1:0]   wdataQ;
    logic [3:0]              cnt;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic [ADDR_WIDTH-1:0]   wordIdx;
    logic [IDX_W-1:0]        idx;
    logic [2:0]              off;
    logic                    misaligned, outOfRange, accessErr, doAccess;
    logic [7:0]              strobe;
    logic [DATA_WIDTH-1:0]   sizeMask, loadData, shiftedWdata;

    assign wordIdx    = (addrQ - BASE_ADDR) >> 3;
    assign idx        = wordIdx[IDX_W-1:0];
    assign off        = addrQ[2:0];
    assign outOfRange = (addrQ < BASE_ADDR) || (wordIdx >= ADDR_WIDTH'(DEPTH));
    assign accessErr  = misaligned || outOfRange;
    assign doAccess   = (state == WAIT) && (cnt == 4'd0);

    always_comb begin
        misaligned = 1'b0;
        strobe     = 8'hFF;
        sizeMask   = '1;
        case (sizeQ)
            2'd0: begin misaligned = 1'b0;         strobe = 8'h01 << off; sizeMask = 64'hFF;        end
            2'd1: begin misaligned = addrQ[0];     strobe = 8'h03 << off; sizeMask = 64'hFFFF;      end
            2'd2: begin misaligned = |addrQ[1:0];  strobe = 8'h0F << off; sizeMask = 64'hFFFF_FFFF; end
            default: begin misaligned = |addrQ[2:0]; strobe = 8'hFF;      sizeMask = '1;            end
        endcase
    end

    assign loadData     = (mem[idx] >> {off, 3'b000}) & sizeMask;
    assign shiftedWdata = wdataQ << {off, 3'b000};

    // Array is never reset; a store aborted by rst never reaches doAccess.
    always_ff @(posedge clk) begin
        if (doAccess && wenQ && !accessErr) begin
            for (int k = 0; k < 8; k++) begin
                if (strobe[k]) mem[idx][8*k +: 8] <= shiftedWdata[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (req_valid) stateNext = WAIT;
            WAIT:    if (cnt == 4'd0) stateNext = RESP;
            RESP:    if (resp_ready) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wenQ       <= 1'b0;
            sizeQ      <= 2'd0;
            addrQ      <= '0;
            wdataQ     <= '0;
            cnt        <= 4'd0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    wenQ   <= req_wen;
                    sizeQ  <= req_size;
                    addrQ  <= req_addr;
                    wdataQ <= req_wdata;
                    cnt    <= 4'(LATENCY);
                end
                WAIT: if (cnt != 4'd0) begin
                    cnt <= cnt - 4'd1;
                end else begin
                    resp_err   <= accessErr;
                    resp_rdata <= (accessErr || wenQ) ? '0 : loadData;
                end
                default: ;
            endcase
        end
    end

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign dbgState   = state;
endmodule
